// File: rtl/rcv_field_capture_pkg.sv
// rcv_pkg: field widths, field-select and FSM enums, and small helpers shared
// by the receive field capture block and its interface.
package rcv_pkg;

   localparam int SYNC_W  = 8;
   localparam int PID_W   = 8;
   localparam int CRC5_W  = 5;
   localparam int CRC16_W = 16;
   localparam int DATA_W  = 64;

   // Bit counter must hold the widest field (64) and count up to it.
   localparam int CNT_W   = 7;

   // A bus bit following this many consecutive ones is a stuff bit.
   localparam int STUFF_RUN = 6;
   localparam int ONES_W    = 3;

   typedef enum logic [2:0] {
      F_NONE  = 3'd0,
      F_SYNC  = 3'd1,
      F_PID   = 3'd2,
      F_CRC5  = 3'd3,
      F_CRC16 = 3'd4,
      F_DATA  = 3'd5
   } field_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_e;

   // Resolve the field-select flags; sync > pid > data > crc16 > crc5.
   function automatic field_e select_field(input logic sync_f, input logic pid_f,
                                           input logic crc5_f, input logic crc16_f,
                                           input logic data_f);
      if (sync_f)       return F_SYNC;
      else if (pid_f)   return F_PID;
      else if (data_f)  return F_DATA;
      else if (crc16_f) return F_CRC16;
      else if (crc5_f)  return F_CRC5;
      else              return F_NONE;
   endfunction

   // Number of bits that complete the given field.
   function automatic logic [CNT_W-1:0] field_width(input field_e f);
      case (f)
         F_SYNC:  return CNT_W'(SYNC_W);
         F_PID:   return CNT_W'(PID_W);
         F_CRC5:  return CNT_W'(CRC5_W);
         F_CRC16: return CNT_W'(CRC16_W);
         F_DATA:  return CNT_W'(DATA_W);
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/rcv_field_capture_if.sv
// rcv_field_capture_if: bit stream, field-select flags and captured fields
// exchanged between the receive control unit (master) and the field capture
// block (slave).
interface rcv_field_capture_if;
   import rcv_pkg::*;

   logic                d_orig;
   logic                shift_enable;
   logic                eop;
   logic                sync_rcving;
   logic                pid_rcving;
   logic                crc5_rcving;
   logic                crc16_rcving;
   logic                data_rcving;

   logic [SYNC_W-1:0]   rcv_sync;
   logic [PID_W-1:0]    rcv_pid;
   logic [CRC5_W-1:0]   rcv_crc5;
   logic [CRC16_W-1:0]  rcv_crc16;
   logic [DATA_W-1:0]   rcv_data;
   logic                sync_bits_received;
   logic                pid_bits_received;
   logic                crc5_bits_received;
   logic                crc16_bits_received;
   logic                data_bits_received;
   logic                stuff_error;

   modport master (
      output d_orig, shift_enable, eop,
             sync_rcving, pid_rcving, crc5_rcving, crc16_rcving, data_rcving,
      input  rcv_sync, rcv_pid, rcv_crc5, rcv_crc16, rcv_data,
             sync_bits_received, pid_bits_received, crc5_bits_received,
             crc16_bits_received, data_bits_received, stuff_error
   );

   modport slave (
      input  d_orig, shift_enable, eop,
             sync_rcving, pid_rcving, crc5_rcving, crc16_rcving, data_rcving,
      output rcv_sync, rcv_pid, rcv_crc5, rcv_crc16, rcv_data,
             sync_bits_received, pid_bits_received, crc5_bits_received,
             crc16_bits_received, data_bits_received, stuff_error
   );

endinterface

// File: rtl/rcv_field_capture_field_bit_counter.sv
// field_bit_counter: clearable bit counter; 'last' flags that the next
// counted bit brings the count up to the field width.
module field_bit_counter
   import rcv_pkg::*;
(
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] width,
   output logic             last
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear has priority over counting
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc)
         cnt_d = cnt_q + 1'b1;
   end

   // Count register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign last = (cnt_q == (width - 1'b1));

endmodule

// File: rtl/rcv_field_capture.sv
// rcv_field_capture: shifts NRZI-decoded bus bits LSB-first into the packet
// field chosen by the receive control unit and pulses that field's
// *_bits_received flag once the field is complete.
// Optional bit unstuffing: define BIT_UNSTUFF_EN.
module rcv_field_capture
   import rcv_pkg::*;
(
   input  logic               clk,
   input  logic               n_rst,
   rcv_field_capture_if.slave bus
);

   state_e state_q, state_d;
   field_e cur_field_q, cur_field_d;
   field_e sel_field;
   logic   cur_flag;
   logic   strobe_ok;
   logic   drop;
   logic   accept;
   logic   cnt_clr;
   logic   cnt_last;
   logic [CNT_W-1:0] cur_width;

   logic [SYNC_W-1:0]  sync_q,  sync_d;
   logic [PID_W-1:0]   pid_q,   pid_d;
   logic [CRC5_W-1:0]  crc5_q,  crc5_d;
   logic [CRC16_W-1:0] crc16_q, crc16_d;
   logic [DATA_W-1:0]  data_q,  data_d;

   // One completion flag per field: [0] sync, [1] pid, [2] crc5, [3] crc16, [4] data
   logic [4:0] done_q, done_d;

`ifdef BIT_UNSTUFF_EN
   logic [ONES_W-1:0] ones_q, ones_d;
   logic              stuff_err_q, stuff_err_d;
`endif

   assign sel_field = select_field(bus.sync_rcving, bus.pid_rcving, bus.crc5_rcving,
                                   bus.crc16_rcving, bus.data_rcving);
   assign cur_width = field_width(cur_field_q);

   // Flag of the field that currently owns the shifter
   always_comb begin
      cur_flag = 1'b0;
      case (cur_field_q)
         F_SYNC:  cur_flag = bus.sync_rcving;
         F_PID:   cur_flag = bus.pid_rcving;
         F_CRC5:  cur_flag = bus.crc5_rcving;
         F_CRC16: cur_flag = bus.crc16_rcving;
         F_DATA:  cur_flag = bus.data_rcving;
         default: cur_flag = 1'b0;
      endcase
   end

   // FSM state and active-field register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         cur_field_q <= F_NONE;
      end else begin
         state_q     <= state_d;
         cur_field_q <= cur_field_d;
      end
   end

   // FSM next state; eop aborts from any state
   always_comb begin
      state_d     = state_q;
      cur_field_d = cur_field_q;
      if (bus.eop) begin
         state_d     = IDLE;
         cur_field_d = F_NONE;
      end else begin
         case (state_q)
            IDLE: begin
               if (sel_field != F_NONE) begin
                  state_d     = SHIFT;
                  cur_field_d = sel_field;
               end
            end
            SHIFT: begin
               if (sel_field == F_NONE) begin
                  state_d     = IDLE;
                  cur_field_d = F_NONE;
               end else if (sel_field != cur_field_q) begin
                  // Field switched mid-shift: restart the count on the new field
                  cur_field_d = sel_field;
               end else if (accept && cnt_last) begin
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (!cur_flag) begin
                  if (sel_field != F_NONE) begin
                     state_d     = SHIFT;
                     cur_field_d = sel_field;
                  end else begin
                     state_d     = IDLE;
                     cur_field_d = F_NONE;
                  end
               end
            end
            default: begin
               state_d     = IDLE;
               cur_field_d = F_NONE;
            end
         endcase
      end
   end

   // FSM outputs: strobe qualification, counter control, completion pulses
   always_comb begin
      strobe_ok = (state_q == SHIFT) && !bus.eop && bus.shift_enable &&
                  (sel_field == cur_field_q);
`ifdef BIT_UNSTUFF_EN
      drop      = strobe_ok && (ones_q == ONES_W'(STUFF_RUN));
`else
      drop      = 1'b0;
`endif
      accept    = strobe_ok && !drop;
      // Counter is held at zero outside an uninterrupted shift of one field
      cnt_clr   = bus.eop || (state_q != SHIFT) || (sel_field != cur_field_q);
      done_d    = '0;
      if (accept && cnt_last) begin
         case (cur_field_q)
            F_SYNC:  done_d[0] = 1'b1;
            F_PID:   done_d[1] = 1'b1;
            F_CRC5:  done_d[2] = 1'b1;
            F_CRC16: done_d[3] = 1'b1;
            F_DATA:  done_d[4] = 1'b1;
            default: done_d    = '0;
         endcase
      end
   end

   field_bit_counter u_bit_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (cnt_clr),
      .inc   (accept),
      .width (cur_width),
      .last  (cnt_last)
   );

   // Shift an accepted bit into the active field's MSB (wire order is LSB first)
   always_comb begin
      sync_d  = sync_q;
      pid_d   = pid_q;
      crc5_d  = crc5_q;
      crc16_d = crc16_q;
      data_d  = data_q;
      if (accept) begin
         case (cur_field_q)
            F_SYNC:  sync_d  = {bus.d_orig, sync_q[SYNC_W-1:1]};
            F_PID:   pid_d   = {bus.d_orig, pid_q[PID_W-1:1]};
            F_CRC5:  crc5_d  = {bus.d_orig, crc5_q[CRC5_W-1:1]};
            F_CRC16: crc16_d = {bus.d_orig, crc16_q[CRC16_W-1:1]};
            F_DATA:  data_d  = {bus.d_orig, data_q[DATA_W-1:1]};
            default: ;
         endcase
      end
   end

   // Field registers and completion pulses; fields persist across packets
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q  <= '0;
         pid_q   <= '0;
         crc5_q  <= '0;
         crc16_q <= '0;
         data_q  <= '0;
         done_q  <= '0;
      end else begin
         sync_q  <= sync_d;
         pid_q   <= pid_d;
         crc5_q  <= crc5_d;
         crc16_q <= crc16_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

`ifdef BIT_UNSTUFF_EN
   // Track the run of accepted ones; the strobe after six ones is a stuff bit
   always_comb begin
      ones_d      = ones_q;
      stuff_err_d = 1'b0;
      if (bus.eop) begin
         ones_d = '0;
      end else if (drop) begin
         ones_d      = '0;
         stuff_err_d = bus.d_orig;
      end else if (accept) begin
         ones_d = bus.d_orig ? (ones_q + 1'b1) : '0;
      end
   end

   // Ones-run counter and stuff error pulse
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ones_q      <= '0;
         stuff_err_q <= 1'b0;
      end else begin
         ones_q      <= ones_d;
         stuff_err_q <= stuff_err_d;
      end
   end

   assign bus.stuff_error = stuff_err_q;
`else
   assign bus.stuff_error = 1'b0;
`endif

   assign bus.rcv_sync            = sync_q;
   assign bus.rcv_pid             = pid_q;
   assign bus.rcv_crc5            = crc5_q;
   assign bus.rcv_crc16           = crc16_q;
   assign bus.rcv_data            = data_q;
   assign bus.sync_bits_received  = done_q[0];
   assign bus.pid_bits_received   = done_q[1];
   assign bus.crc5_bits_received  = done_q[2];
   assign bus.crc16_bits_received = done_q[3];
   assign bus.data_bits_received  = done_q[4];

endmodule

// File: tb/tb_rcv_field_capture.sv
// tb_rcv_field_capture: scoreboard bench for rcv_field_capture. Each complete
// field sent pushes the expected field, value and pulse cycle; a monitor pops
// and compares whenever a *_bits_received pulse appears.
module tb_rcv_field_capture;

   localparam logic [4:0] M_SYNC  = 5'b00001;
   localparam logic [4:0] M_PID   = 5'b00010;
   localparam logic [4:0] M_CRC5  = 5'b00100;
   localparam logic [4:0] M_CRC16 = 5'b01000;
   localparam logic [4:0] M_DATA  = 5'b10000;

   typedef struct {
      int          fld;
      logic [63:0] val;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic n_rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   n_stuff = 0;
   int   exp_stuff = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rcv_field_capture_if bus ();

   rcv_field_capture dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [4:0] pulses();
      return {bus.data_bits_received, bus.crc16_bits_received, bus.crc5_bits_received,
              bus.pid_bits_received, bus.sync_bits_received};
   endfunction

   task automatic chk_zero(input string t);
      chk({t, "_sync"},   64'(bus.rcv_sync),  64'h0);
      chk({t, "_pid"},    64'(bus.rcv_pid),   64'h0);
      chk({t, "_crc5"},   64'(bus.rcv_crc5),  64'h0);
      chk({t, "_crc16"},  64'(bus.rcv_crc16), 64'h0);
      chk({t, "_data"},   bus.rcv_data,       64'h0);
      chk({t, "_pulses"}, 64'(pulses()),      64'h0);
      chk({t, "_stuff"},  64'(bus.stuff_error), 64'h0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_flags(input logic [4:0] f);
      bus.sync_rcving  = f[0];
      bus.pid_rcving   = f[1];
      bus.crc5_rcving  = f[2];
      bus.crc16_rcving = f[3];
      bus.data_rcving  = f[4];
      @(negedge clk);
   endtask

   task automatic strobe(input logic b);
      bus.d_orig       = b;
      bus.shift_enable = 1'b1;
      @(negedge clk);
      bus.shift_enable = 1'b0;
      bus.d_orig       = 1'b0;
   endtask

   // Expect the field pulse in the cycle following the next strobe's edge
   task automatic push(input int fld, input logic [63:0] v);
      exp_t e;
      e.fld = fld;
      e.val = v;
      e.cyc = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic send(input int fld, input logic [63:0] v, input int n, input bit full);
      for (int i = 0; i < n; i++) begin
         if (full && (i == n - 1))
            push(fld, v);
         strobe(v[i]);
      end
   endtask

   task automatic pulse_eop();
      bus.eop = 1'b1;
      @(negedge clk);
      bus.eop = 1'b0;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin : mon
      logic [4:0]  pv;
      logic [63:0] got;
      exp_t        e;
      pv = pulses();
      if (bus.stuff_error === 1'b1)
         n_stuff++;
      if (pv != 5'b0) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", 64'(pv), 64'h0);
         end else begin
            e = sb.pop_front();
            chk("pulse_field", 64'(pv), 64'h1 << e.fld);
            chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
            case (e.fld)
               0:       got = 64'(bus.rcv_sync);
               1:       got = 64'(bus.rcv_pid);
               2:       got = 64'(bus.rcv_crc5);
               3:       got = 64'(bus.rcv_crc16);
               default: got = bus.rcv_data;
            endcase
            chk("field_value", got, e.val);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.d_orig       = 1'b0;
      bus.shift_enable = 1'b0;
      bus.eop          = 1'b0;
      bus.sync_rcving  = 1'b0;
      bus.pid_rcving   = 1'b0;
      bus.crc5_rcving  = 1'b0;
      bus.crc16_rcving = 1'b0;
      bus.data_rcving  = 1'b0;
      n_rst            = 1'b0;
      idle(2);
      chk_zero("reset");
      n_rst = 1'b1;
      idle(2);

      // sync 8'h80, LSB first
      set_flags(M_SYNC);
      send(0, 64'h80, 8, 1'b1);
      set_flags(5'b0);
      idle(1);

      // pid 8'h96 then three ignored strobes while the flag is held
      set_flags(M_PID);
      send(1, 64'h96, 8, 1'b1);
      repeat (3) strobe(1'b1);
      chk("pid_after_extra", 64'(bus.rcv_pid), 64'h96);
      set_flags(5'b0);
      idle(1);

      // 64-bit data field
      set_flags(M_DATA);
      send(4, 64'h0123_4567_89AB_CDEF, 64, 1'b1);
      set_flags(5'b0);
      idle(1);

      // crc16 aborted by eop after 3 bits, then a full 16'hBEEF
      set_flags(M_CRC16);
      send(3, 64'h5, 3, 1'b0);
      bus.crc16_rcving = 1'b0;
      pulse_eop();
      idle(2);
      set_flags(M_CRC16);
      send(3, 64'hBEEF, 16, 1'b1);
      set_flags(5'b0);
      idle(1);

      // eop wins over a simultaneous strobe
      set_flags(M_CRC5);
      send(2, 64'hD, 4, 1'b0);
      bus.crc5_rcving  = 1'b0;
      bus.d_orig       = 1'b1;
      bus.shift_enable = 1'b1;
      bus.eop          = 1'b1;
      @(negedge clk);
      bus.shift_enable = 1'b0;
      bus.d_orig       = 1'b0;
      bus.eop          = 1'b0;
      chk("crc5_eop_wins", 64'(bus.rcv_crc5), 64'h1A);
      idle(1);

      // crc16 beats crc5; dropping crc16 in HOLD hands over to crc5
      set_flags(M_CRC16 | M_CRC5);
      send(3, 64'h1234, 16, 1'b1);
      set_flags(M_CRC5);
      send(2, 64'h0A, 5, 1'b1);
      chk("crc16_kept", 64'(bus.rcv_crc16), 64'h1234);
      set_flags(5'b0);
      idle(1);

`ifdef BIT_UNSTUFF_EN
      // six ones + stuffed zero dropped; six ones + one is a violation, dropped
      pulse_eop();
      set_flags(M_DATA);
      repeat (6) strobe(1'b1);
      strobe(1'b0);
      repeat (6) strobe(1'b1);
      strobe(1'b1);
      exp_stuff = 1;
      repeat (51) strobe(1'b0);
      push(4, 64'h0FFF);
      strobe(1'b0);
      set_flags(5'b0);
      idle(2);
`endif

      // reset mid-pid discards the partial field; then a full 8'h2D
      set_flags(M_PID);
      send(1, 64'hA, 4, 1'b0);
      n_rst = 1'b0;
      idle(1);
      chk_zero("midreset");
      n_rst = 1'b1;
      idle(1);
      send(1, 64'h2D, 8, 1'b1);
      set_flags(5'b0);
      idle(3);

      chk("sb_drained", 64'(sb.size()), 64'h0);
      chk("stuff_err_count", 64'(n_stuff), 64'(exp_stuff));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rcv_field_capture.md
RCV_FIELD_CAPTURE -- requirements
Module: rcv_field_capture

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port d_orig  input  1  NRZI-decoded bus bit, valid when shift_enable=1.
REQ-004 SHALL have port shift_enable  input  1  one-cycle strobe per sampled bus bit.
REQ-005 SHALL have port eop  input  1  end-of-packet detected.
REQ-006 SHALL have ports sync_rcving, pid_rcving, crc5_rcving, crc16_rcving, data_rcving  input  1 each  field-select flags from the receive control unit.
REQ-007 SHALL have ports rcv_sync [7:0], rcv_pid [7:0], rcv_crc5 [4:0], rcv_crc16 [15:0], rcv_data [63:0]  output  captured fields.
REQ-008 SHALL have ports sync_bits_received, pid_bits_received, crc5_bits_received, crc16_bits_received, data_bits_received  output  1 each  field-complete pulses.
REQ-009 SHALL have port stuff_error  output  1  one-cycle bit-stuffing violation pulse.

Function
REQ-010 Active field SHALL be the asserted rcving flag, priority sync > pid > data > crc16 > crc5 when several are asserted.
REQ-011 FSM states SHALL be IDLE, SHIFT, HOLD.
REQ-012 IDLE -> SHIFT when any rcving flag is 1; bit counter cleared on entry.
REQ-013 In SHIFT, each shift_enable SHALL right-shift the active field register, d_orig into MSB (LSB-first wire order); other registers unchanged.
REQ-014 Bit counter (7 bits) SHALL increment per accepted bit; on the bit that makes count equal field width (8/8/5/16/64) SHALL go to HOLD.
REQ-015 The matching *_bits_received SHALL pulse high exactly one cycle, the cycle after the edge loading the final bit; the field register is already final in that cycle.
REQ-016 In HOLD, shift_enable SHALL be ignored; when the active field's flag deasserts: -> SHIFT (counter cleared) if another flag is asserted, else -> IDLE.
REQ-017 Active-field change while in SHIFT (flag switch before width reached) SHALL clear the counter, discard partial count, keep old register contents.
REQ-018 shift_enable with no rcving flag asserted SHALL be ignored.
REQ-019 eop=1 SHALL force IDLE and clear counters next edge; field registers SHALL retain values; eop wins over a simultaneous shift_enable.
REQ-020 Field registers SHALL NOT be cleared between packets; each field overwritten only by new shifts.

Reset
REQ-021 n_rst=0 SHALL asynchronously force IDLE, counters 0, all rcv_* registers 0, all *_bits_received 0, stuff_error 0.
REQ-022 Reset mid-field SHALL discard partial data with no pulse on release.

Configuration
REQ-023 Macro BIT_UNSTUFF_EN defined: consecutive-ones counter SHALL track accepted bits; after six consecutive 1s the next strobed bit SHALL be discarded (no shift, no count), ones counter cleared; if that bit is 1, stuff_error SHALL pulse one cycle.
REQ-024 Ones counter SHALL clear on any 0 bit, on eop, and on reset.
REQ-025 Macro BIT_UNSTUFF_EN undefined: every strobed bit accepted; stuff_error tied 0.

Structure
REQ-026 Package rcv_pkg SHALL hold field width constants (SYNC_W=8, PID_W=8, CRC5_W=5, CRC16_W=16, DATA_W=64) and the field-select enum (F_NONE, F_SYNC, F_PID, F_CRC5, F_CRC16, F_DATA).
REQ-027 Sub-module field_bit_counter SHALL implement the clearable counter with compare-to-width terminal flag.

Verification
REQ-028 sync_rcving=1, 8 strobes LSB-first 0,0,0,0,0,0,0,1 -> rcv_sync=8'h80, sync_bits_received one-cycle pulse one cycle after eighth strobe.
REQ-029 pid_rcving=1, bits of 8'h96 LSB-first, then 3 extra strobes while flag held -> rcv_pid=8'h96, single pulse, extra strobes ignored.
REQ-030 data_rcving=1, 64 bits of 64'h0123_4567_89AB_CDEF -> rcv_data matches, data_bits_received after 64th strobe only.
REQ-031 eop asserted after 3 crc16 bits, then crc16_rcving re-asserted with 16 bits of 16'hBEEF -> no pulse on abort, rcv_crc16=16'hBEEF then pulse.
REQ-032 BIT_UNSTUFF_EN: six 1s then 0 then 1 in data field -> stuffed 0 dropped, count advances 7; six 1s then 1 -> stuff_error pulse, bit dropped.
REQ-033 n_rst low after 4 pid bits, release, send 8 bits 8'h2D -> all outputs 0 during reset, rcv_pid=8'h2D with one pulse.
